fetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter register.
- Issues instruction-memory requests at the current PC and tells the PC register when to advance.
- Buffers in-order fetch results with their PCs in a small slot queue and presents them to decode with a valid/stall handshake.
- Handles branch/exception flush, including discarding responses still in flight.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue_checker.sv | 25 ++
 rtl/fetch_queue_slot_array.sv | 73 +++++++
 rtl/fetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_queue.sv | 156 +++++++++++++++
 6 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants, slot record and small helpers for the instruction-fetch queue.
package fetch_queue_pkg;

    localparam int          XLEN      = 32;
    localparam logic        RESET_LO  = 1'b0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } slot_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory and decode handshake bundle of the fetch stage.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_gnt;
    logic            i_imem_rvalid;
    logic [XLEN-1:0] i_imem_rdata;
    logic            o_valid;
    logic [XLEN-1:0] o_instr;
    logic [XLEN-1:0] o_instr_pc;
    logic            i_stall;
    logic            i_flush;

    modport master (
        output o_imem_req, o_imem_addr, o_valid, o_instr, o_instr_pc,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_stall, i_flush
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_valid, o_instr, o_instr_pc,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_stall, i_flush
    );

endinterface

// File: rtl/fetch_queue_checker.sv
// Protocol checks for the fetch queue: every kept response needs a waiting slot,
// and the discard counter must not wrap when a flush folds unfilled slots into it.
module fetch_queue_checker #(
    parameter int CW = 2
) (
    input logic          i_clk,
    input logic          i_rst,
    input logic          i_clk_en,
    input logic          i_rvalid,
    input logic          i_flush,
    input logic [CW-1:0] i_discard,
    input logic [CW-1:0] i_unfilled
);

    localparam logic [CW:0] MAX_DISCARD = {1'b0, {CW{1'b1}}};

    a_rsp_has_slot: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_clk_en && i_rvalid && (i_discard == '0)) |-> (i_unfilled != '0))
        else $error("fetch_queue: response with no unfilled slot");

    a_discard_fits: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_clk_en && i_flush) |-> (({1'b0, i_discard} + {1'b0, i_unfilled}) <= MAX_DISCARD))
        else $error("fetch_queue: discard counter overflow");

endmodule

// File: rtl/fetch_queue_slot_array.sv
// Slot storage for in-order fetches: head/alloc/fill pointers, occupancy and unfilled counts.
module fetch_slot_array
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_en,
    input  logic            i_flush,
    input  logic            i_alloc,
    input  logic [XLEN-1:0] i_alloc_pc,
    input  logic            i_fill,
    input  logic [XLEN-1:0] i_fill_instr,
    input  logic            i_pop,
    output logic [CW-1:0]   o_count,
    output logic [CW-1:0]   o_unfilled,
    output slot_t           o_head
);

    localparam int PW = $clog2(DEPTH);

    slot_t          r_slots [DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_alloc;
    logic [PW-1:0]  r_fill;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_unfilled;

    // Slot contents, pointers and counters; flush drops every allocation at once.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= '0;
            end
            r_head     <= '0;
            r_alloc    <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
        end else if (i_clk_en) begin
            if (i_flush) begin
                r_head     <= '0;
                r_alloc    <= '0;
                r_fill     <= '0;
                r_count    <= '0;
                r_unfilled <= '0;
            end else begin
                if (i_alloc) begin
                    r_slots[r_alloc].pc     <= i_alloc_pc;
                    r_slots[r_alloc].filled <= 1'b0;
                    r_alloc                 <= r_alloc + PW'(1);
                end
                if (i_fill) begin
                    r_slots[r_fill].instr  <= i_fill_instr;
                    r_slots[r_fill].filled <= 1'b1;
                    r_fill                 <= r_fill + PW'(1);
                end
                if (i_pop) begin
                    r_head <= r_head + PW'(1);
                end
                r_count    <= r_count + CW'(i_alloc) - CW'(i_pop);
                r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
            end
        end
    end

    assign o_count    = r_count;
    assign o_unfilled = r_unfilled;
    assign o_head     = r_slots[r_head];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: requests at the PC, queues in-order results for decode, handles flush.
// Optional PC misalignment check enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_en,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_pc_wr_en,
    input  logic            i_exception_f_stall,
    fetch_queue_if.master   fq,
    output logic            o_misalign
);

    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_unfilled;
    slot_t           w_head;
    logic            w_req_base;
    logic            w_req;
    logic            w_grant;
    logic            w_fill;
    logic            w_valid;
    logic            w_pop;
    logic [XLEN-1:0] w_instr;
    logic [XLEN-1:0] w_instr_pc;
    logic [CW-1:0]   r_discard;

    // Request depends only on enable, reset, flush, exception stall and occupancy.
    assign w_req_base = i_clk_en & ~i_rst & ~fq.i_flush & ~i_exception_f_stall
                      & (w_count < CW'(DEPTH));

`ifdef FETCH_MISALIGN_CHECK_EN
    logic w_pc_misaligned;
    logic r_misalign;

    assign w_pc_misaligned = ~is_word_aligned(i_pc);
    assign w_req           = w_req_base & ~w_pc_misaligned;

    // Sticky misalign flag, set by a suppressed request and cleared only by flush.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_misalign <= 1'b0;
        end else if (i_clk_en) begin
            if (fq.i_flush) begin
                r_misalign <= 1'b0;
            end else if (w_req_base && w_pc_misaligned) begin
                r_misalign <= 1'b1;
            end else begin
                r_misalign <= r_misalign;
            end
        end else begin
            r_misalign <= r_misalign;
        end
    end

    assign o_misalign = r_misalign;
`else
    assign w_req      = w_req_base;
    assign o_misalign = 1'b0;
`endif

    assign w_grant = w_req & fq.i_imem_gnt;
    assign w_fill  = i_clk_en & fq.i_imem_rvalid & (r_discard == '0) & ~fq.i_flush;
    assign w_valid = w_head.filled & (w_count != '0);
    assign w_pop   = w_valid & ~fq.i_stall & i_clk_en;

    fetch_slot_array #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_slots (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clk_en     (i_clk_en),
        .i_flush      (fq.i_flush),
        .i_alloc      (w_grant),
        .i_alloc_pc   (i_pc),
        .i_fill       (w_fill),
        .i_fill_instr (fq.i_imem_rdata),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_unfilled   (w_unfilled),
        .o_head       (w_head)
    );

    // Responses owed to flushed requests; a response arriving in the flush cycle retires one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_discard <= '0;
        end else if (i_clk_en) begin
            if (fq.i_flush) begin
                r_discard <= r_discard + w_unfilled - CW'(fq.i_imem_rvalid);
            end else if (fq.i_imem_rvalid && (r_discard != '0)) begin
                r_discard <= r_discard - CW'(1);
            end else begin
                r_discard <= r_discard;
            end
        end else begin
            r_discard <= r_discard;
        end
    end

    // Head presentation; an empty or unfilled head shows a NOP at PC 0.
    always_comb begin
        w_instr    = NOP_INSTR;
        w_instr_pc = 32'h0000_0000;
        if (w_valid) begin
            w_instr    = w_head.instr;
            w_instr_pc = w_head.pc;
        end else begin
            w_instr    = NOP_INSTR;
            w_instr_pc = 32'h0000_0000;
        end
    end

    assign fq.o_imem_req  = w_req;
    assign fq.o_imem_addr = i_pc;
    assign o_pc_wr_en     = w_grant;
    assign fq.o_valid     = w_valid;
    assign fq.o_instr     = w_instr;
    assign fq.o_instr_pc  = w_instr_pc;

`ifndef SYNTHESIS
    fetch_queue_checker #(
        .CW (CW)
    ) u_checker (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clk_en   (i_clk_en),
        .i_rvalid   (fq.i_imem_rvalid),
        .i_flush    (fq.i_flush),
        .i_discard  (r_discard),
        .i_unfilled (w_unfilled)
    );
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH = 2).
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        rst, en;
        logic [31:0] pc;
        logic        exc, gnt, rv;
        logic [31:0] rd;
        logic        stall, flush;
        logic        req, wr, valid;
        logic [31:0] instr, ipc;
        logic        mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, en, exc, wr, mis;
    logic [31:0] pc;
    int          n_total = 0;
    int          n_pass  = 0;
    vec_t        tbl[$];

    fetch_queue_if fq();

    fetch_queue #(.DEPTH(2)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_clk_en            (en),
        .i_pc                (pc),
        .o_pc_wr_en          (wr),
        .i_exception_f_stall (exc),
        .fq                  (fq),
        .o_misalign          (mis)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic [31:0] p,
                                input logic x, input logic g, input logic v,
                                input logic [31:0] d, input logic s, input logic f,
                                input logic q, input logic w, input logic ov,
                                input logic [31:0] oi, input logic [31:0] op, input logic m);
        vec_t t;
        t.rst = r; t.en = e; t.pc = p; t.exc = x; t.gnt = g; t.rv = v; t.rd = d;
        t.stall = s; t.flush = f; t.req = q; t.wr = w; t.valid = ov;
        t.instr = oi; t.ipc = op; t.mis = m;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t t, input string nm);
        @(negedge clk);
        rst = t.rst; en = t.en; pc = t.pc; exc = t.exc;
        fq.i_imem_gnt = t.gnt; fq.i_imem_rvalid = t.rv; fq.i_imem_rdata = t.rd;
        fq.i_stall = t.stall; fq.i_flush = t.flush;
        #1;
        chk({nm, ".req"},   {31'h0, fq.o_imem_req}, {31'h0, t.req});
        chk({nm, ".addr"},  fq.o_imem_addr,         t.pc);
        chk({nm, ".wr"},    {31'h0, wr},            {31'h0, t.wr});
        chk({nm, ".valid"}, {31'h0, fq.o_valid},    {31'h0, t.valid});
        chk({nm, ".instr"}, fq.o_instr,             t.instr);
        chk({nm, ".ipc"},   fq.o_instr_pc,          t.ipc);
        chk({nm, ".mis"},   {31'h0, mis},           {31'h0, t.mis});
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; pc = 32'h0; exc = 1'b0;
        fq.i_imem_gnt = 1'b0; fq.i_imem_rvalid = 1'b0; fq.i_imem_rdata = 32'h0;
        fq.i_stall = 1'b0; fq.i_flush = 1'b0;
        repeat (2) @(posedge clk);

        //          rst   en    pc            exc   gnt   rv    rdata         stall flush  req   wr    valid instr         ipc           mis
        // single fetch: request, 1-cycle response, valid two cycles after request
        tbl.push_back(mk(1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP,          32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,          32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,          32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00500093, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,          32'h0,        1'b0));
        // stall 6 cycles with continuous grants: two grants, then full
        tbl.push_back(mk(1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP,          32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, NOP,          32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, NOP,          32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 32'hA1,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NOP,          32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 32'hA2,       1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1,       32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1,       32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1,       32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1,       32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA2,       32'h4,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,          32'h0,        1'b0));
        // clock enable low for 4 cycles with a valid head
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,          32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b1, 32'hB1,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,          32'h0,        1'b0));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(1'b0, 1'b0, 32'h0000_000C, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB1,       32'h8,        1'b0));
        end
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hB1,       32'h8,        1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,          32'h0,        1'b0));
        // exception stall blocks requests
        tbl.push_back(mk(1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP,          32'h0,        1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // flush with two requests in flight (3-cycle latency): both responses dropped
        step(mk(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,     32'h0,   1'b0), "flA1");
        step(mk(1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,     32'h0,   1'b0), "flA2");
        step(mk(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "flA3");
        step(mk(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'hDEAD0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "flA4");
        step(mk(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 32'hDEAD0002, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,     32'h0,   1'b0), "flA5");
        step(mk(1'b0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "flA6");
        step(mk(1'b0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b1, 32'hC100,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "flA7");
        step(mk(1'b0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hC100, 32'h100, 1'b0), "flA8");
        step(mk(1'b0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "flA9");

        // flush in the same cycle as an in-flight response: one more response dropped
        step(mk(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,     32'h0,   1'b0), "flB1");
        step(mk(1'b0, 1'b1, 32'h0000_0204, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,     32'h0,   1'b0), "flB2");
        step(mk(1'b0, 1'b1, 32'h0000_0208, 1'b0, 1'b1, 1'b1, 32'hDEAD0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "flB3");
        step(mk(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b1, 1'b1, 32'hDEAD0004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,     32'h0,   1'b0), "flB4");
        step(mk(1'b0, 1'b1, 32'h0000_0304, 1'b0, 1'b0, 1'b1, 32'hC300,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "flB5");
        step(mk(1'b0, 1'b1, 32'h0000_0304, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hC300, 32'h300, 1'b0), "flB6");
        step(mk(1'b0, 1'b1, 32'h0000_0304, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "flB7");

        // flush while a filled head is presented: valid drops the next cycle
        step(mk(1'b0, 1'b1, 32'h0000_0400, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,     32'h0,   1'b0), "flC1");
        step(mk(1'b0, 1'b1, 32'h0000_0404, 1'b0, 1'b0, 1'b1, 32'hC400,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "flC2");
        step(mk(1'b0, 1'b1, 32'h0000_0404, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC400, 32'h400, 1'b0), "flC3");
        step(mk(1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "flC4");

`ifdef FETCH_MISALIGN_CHECK_EN
        step(mk(1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "mis1");
        step(mk(1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP,     32'h0,   1'b1), "mis2");
        step(mk(1'b0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,     32'h0,   1'b1), "mis3");
        step(mk(1'b0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NOP,     32'h0,   1'b1), "mis4");
        step(mk(1'b0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "mis5");
`else
        step(mk(1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,     32'h0,   1'b0), "mis1");
        step(mk(1'b0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "mis2");
        step(mk(1'b0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,     32'h0,   1'b0), "mis3");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
